// File: rtl/ddr_ca_dly_line_ctrl_pkg.sv
// Shared constants for the DDR3 CA delay-line controller: FSM state codes,
// the direction encoding, and the move counter width.
package ddr_ca_dly_pkg;

    localparam int MOVE_CNT_W = 16;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_RST_LOAD = 3'd0;
    localparam state_t ST_IDLE     = 3'd1;
    localparam state_t ST_LOAD     = 3'd2;
    localparam state_t ST_SETUP    = 3'd3;
    localparam state_t ST_MOVE     = 3'd4;
    localparam state_t ST_GAP      = 3'd5;
    localparam state_t ST_FIN      = 3'd6;

    // Which pulse the current GAP follows; selects the exit from GAP.
    typedef logic [1:0] gap_src_t;

    localparam gap_src_t SRC_RST  = 2'd0;
    localparam gap_src_t SRC_LOAD = 2'd1;
    localparam gap_src_t SRC_MOVE = 2'd2;

endpackage

// File: rtl/ddr_ca_dly_line_ctrl_if.sv
// Request/completion handshake between CA training logic and the
// delay-line controller.
interface ddr_ca_dly_line_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_LOAD;
    logic [TAP_W-1:0] REQ_TAP;
    logic             DONE;
    logic             DONE_ERR;

    modport master (
        output REQ_VALID, REQ_LOAD, REQ_TAP,
        input  REQ_READY, DONE, DONE_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_LOAD, REQ_TAP,
        output REQ_READY, DONE, DONE_ERR
    );
endinterface

// File: rtl/ddr_ca_dly_line_ctrl_gap_timer.sv
// Loadable down-counter that paces delay-line pulses; tc is high on the
// last of MOVE_GAP idle cycles following a start.
module ddr_ca_dly_gap_timer #(
    parameter int MOVE_GAP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic tc
);
    localparam int CW = $clog2(MOVE_GAP + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = CW'(MOVE_GAP);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CW'(1));

endmodule

// File: rtl/ddr_ca_dly_line_ctrl.sv
// Transmit delay-line controller for one DDR3 CA IOD lane: turns absolute
// tap requests into paced single-tap moves. Optional macro DDR_CA_DLY_MOVE_CNT_EN.
module ddr_ca_dly_line_ctrl
    import ddr_ca_dly_pkg::*;
#(
    parameter int TAP_W    = 8,
    parameter int INIT_TAP = 1,
    parameter int MAX_TAP  = 255,
    parameter int MOVE_GAP = 4
) (
    input  logic                  FAB_CLK,
    input  logic                  SYNC_RST,
    ddr_ca_dly_line_ctrl_if.slave req,
    output logic [TAP_W-1:0]      CUR_TAP,
    output logic                  ERR_OOR,
    input  logic                  ERR_CLR,
    output logic                  DELAY_LINE_LOAD,
    output logic                  DELAY_LINE_MOVE,
    output logic                  DELAY_LINE_DIRECTION,
    input  logic                  DELAY_LINE_OUT_OF_RANGE,
    output logic [MOVE_CNT_W-1:0] MOVE_CNT
);
    localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);

    state_t           state_q, state_d;
    gap_src_t         src_q, src_d;
    logic [TAP_W-1:0] cur_q, cur_d;
    logic [TAP_W-1:0] tgt_q, tgt_d;
    logic             dir_q, dir_d;
    logic             derr_q, derr_d;
    logic             err_q, err_d;
    logic [TAP_W-1:0] req_tgt;
    logic             gap_start, gap_tc;

    assign req_tgt = (req.REQ_TAP > MAX_T) ? MAX_T : req.REQ_TAP;

    assign gap_start = !SYNC_RST &&
                       (state_q == ST_RST_LOAD || state_q == ST_LOAD || state_q == ST_MOVE);

    ddr_ca_dly_gap_timer #(.MOVE_GAP(MOVE_GAP)) u_gap (
        .clk   (FAB_CLK),
        .rst   (SYNC_RST),
        .start (gap_start),
        .tc    (gap_tc)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        derr_d  = derr_q;
        err_d   = err_q & ~ERR_CLR;
        case (state_q)
            ST_RST_LOAD: begin
                cur_d   = INIT_T;
                src_d   = SRC_RST;
                state_d = ST_GAP;
            end
            ST_IDLE: begin
                if (req.REQ_VALID) begin
                    tgt_d  = req_tgt;
                    derr_d = 1'b0;
                    dir_d  = DIR_DEC;
                    if (req.REQ_LOAD)
                        state_d = ST_LOAD;
                    else if (req_tgt == cur_q)
                        state_d = ST_FIN;
                    else begin
                        dir_d   = (req_tgt > cur_q) ? DIR_INC : DIR_DEC;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_LOAD: begin
                cur_d   = INIT_T;
                src_d   = SRC_LOAD;
                state_d = ST_GAP;
            end
            ST_SETUP: begin
                src_d   = SRC_MOVE;
                state_d = ST_MOVE;
            end
            ST_MOVE: begin
                cur_d   = (dir_q == DIR_INC) ? cur_q + 1'b1 : cur_q - 1'b1;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_tc) begin
                    case (src_q)
                        SRC_RST:  state_d = ST_IDLE;
                        SRC_LOAD: state_d = ST_FIN;
                        default: begin
                            // The IOD rejected the last step: undo it so CUR_TAP matches hardware.
                            if (DELAY_LINE_OUT_OF_RANGE) begin
                                err_d   = 1'b1;
                                derr_d  = 1'b1;
                                cur_d   = (dir_q == DIR_INC) ? cur_q - 1'b1 : cur_q + 1'b1;
                                state_d = ST_FIN;
                            end else if (cur_q == tgt_q)
                                state_d = ST_FIN;
                            else
                                state_d = ST_MOVE;
                        end
                    endcase
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q <= ST_RST_LOAD;
            src_q   <= SRC_RST;
            cur_q   <= INIT_T;
            tgt_q   <= INIT_T;
            dir_q   <= DIR_DEC;
            derr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            dir_q   <= dir_d;
            derr_q  <= derr_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by reset so the IOD sees nothing while SYNC_RST is high.
    assign req.REQ_READY        = !SYNC_RST && (state_q == ST_IDLE);
    assign req.DONE             = !SYNC_RST && (state_q == ST_FIN);
    assign req.DONE_ERR         = !SYNC_RST && (state_q == ST_FIN) && derr_q;
    assign DELAY_LINE_LOAD      = !SYNC_RST && (state_q == ST_RST_LOAD || state_q == ST_LOAD);
    assign DELAY_LINE_MOVE      = !SYNC_RST && (state_q == ST_MOVE);
    assign DELAY_LINE_DIRECTION = !SYNC_RST && dir_q &&
                                  (state_q == ST_SETUP || state_q == ST_MOVE || state_q == ST_FIN ||
                                   (state_q == ST_GAP && src_q == SRC_MOVE));
    assign CUR_TAP              = SYNC_RST ? INIT_T : cur_q;
    assign ERR_OOR              = !SYNC_RST && err_q;

`ifdef DDR_CA_DLY_MOVE_CNT_EN
    logic [MOVE_CNT_W-1:0] mcnt_q, mcnt_d;

    always_comb begin
        mcnt_d = mcnt_q;
        if (DELAY_LINE_MOVE && mcnt_q != '1)
            mcnt_d = mcnt_q + 1'b1;
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST)
            mcnt_q <= '0;
        else
            mcnt_q <= mcnt_d;
    end

    assign MOVE_CNT = mcnt_q;
`else
    assign MOVE_CNT = '0;
`endif

endmodule

// File: tb/tb_ddr_ca_dly_line_ctrl.sv
// Bench for ddr_ca_dly_line_ctrl: directed vector table, OOR and mid-request
// reset sequences, then random requests against a tap/latency model.
module tb_ddr_ca_dly_line_ctrl;
    localparam int TAP_W    = 9;
    localparam int INIT_TAP = 1;
    localparam int MAX_TAP  = 255;
    localparam int G        = 4;
    localparam int BOUND    = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             err_clr = 1'b0;
    logic             oor = 1'b0;
    logic [TAP_W-1:0] cur_tap;
    logic             err_oor, dl_load, dl_move, dl_dir;
    logic [15:0]      move_cnt;

    ddr_ca_dly_line_ctrl_if #(.TAP_W(TAP_W)) rq();

    ddr_ca_dly_line_ctrl #(
        .TAP_W(TAP_W), .INIT_TAP(INIT_TAP), .MAX_TAP(MAX_TAP), .MOVE_GAP(G)
    ) dut (
        .FAB_CLK                 (clk),
        .SYNC_RST                (rst),
        .req                     (rq),
        .CUR_TAP                 (cur_tap),
        .ERR_OOR                 (err_oor),
        .ERR_CLR                 (err_clr),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .MOVE_CNT                (move_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: cycle stamps of every MOVE/LOAD, and pulse-spacing violations.
    int mv_q[$];
    int ld_q[$];
    bit dirs[$];
    bit proto_bad = 1'b0;
    bit prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (dl_move) begin mv_q.push_back(cyc); dirs.push_back(dl_dir); end
        if (dl_load) ld_q.push_back(cyc);
        if ((dl_move && dl_load) || (prev_pulse && (dl_move || dl_load))) proto_bad = 1'b1;
        prev_pulse = dl_move || dl_load;
    end

    int total = 0;
    int bad   = 0;
    int m_cur;
    longint m_mvtot;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_mcnt(input string nm);
`ifdef DDR_CA_DLY_MOVE_CNT_EN
        chk({nm, " move_cnt"}, move_cnt, (m_mvtot > 65535) ? 65535 : m_mvtot);
`else
        chk({nm, " move_cnt"}, move_cnt, 0);
`endif
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Release reset and expect one LOAD in the first cycle, READY G+1 cycles later.
    task automatic reset_release(input string nm);
        int t0, w;
        bit saw_done;
        ld_q.delete();
        rst = 1'b0;
        t0 = cyc;
        w = 0;
        saw_done = 1'b0;
        while (rq.REQ_READY !== 1'b1 && w < BOUND) begin
            if (rq.DONE === 1'b1) saw_done = 1'b1;
            tick();
            w++;
        end
        chk({nm, " ready delay"}, w, G + 1);
        chk({nm, " load count"}, ld_q.size(), 1);
        if (ld_q.size() > 0) chk({nm, " load cycle"}, ld_q[0] - t0, 0);
        chk({nm, " no done"}, saw_done, 0);
        chk({nm, " cur_tap"}, cur_tap, INIT_TAP);
        m_cur = INIT_TAP;
        m_mvtot = 0;
        chk_mcnt(nm);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " rst ready"}, rq.REQ_READY, 0);
        chk({nm, " rst done"}, rq.DONE, 0);
        chk({nm, " rst load/move/dir"}, {dl_load, dl_move, dl_dir}, 0);
        chk({nm, " rst err"}, err_oor, 0);
        chk({nm, " rst cur_tap"}, cur_tap, INIT_TAP);
        chk({nm, " rst move_cnt"}, move_cnt, 0);
    endtask

    task automatic do_req(input string nm, input bit ld, input int tap, input int oor_at,
                          input int e_cur, input int e_mv, input int e_lat,
                          input bit e_dir, input bit e_err);
        int w, t0, lat;
        bit dn, derr, tbad, dbad, setup_dir;
        w = 0;
        while (rq.REQ_READY !== 1'b1 && w < BOUND) begin tick(); w++; end
        chk({nm, " ready"}, rq.REQ_READY, 1);
        rq.REQ_VALID = 1'b1;
        rq.REQ_LOAD  = ld;
        rq.REQ_TAP   = TAP_W'(tap);
        mv_q.delete(); ld_q.delete(); dirs.delete();
        t0 = cyc;
        tick();
        rq.REQ_VALID = 1'b0;
        rq.REQ_LOAD  = 1'b0;
        setup_dir = dl_dir;
        lat = 1;
        dn = 1'b0;
        derr = 1'b0;
        while (lat < BOUND) begin
            if (oor_at > 0 && mv_q.size() >= oor_at) oor = 1'b1;
            if (rq.DONE === 1'b1) begin dn = 1'b1; derr = rq.DONE_ERR; break; end
            tick();
            lat++;
        end
        oor = 1'b0;
        m_mvtot += e_mv;
        chk({nm, " done"}, dn, 1);
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " done_err"}, derr, e_err);
        chk({nm, " cur_tap"}, cur_tap, e_cur);
        chk({nm, " moves"}, mv_q.size(), e_mv);
        chk({nm, " loads"}, ld_q.size(), ld);
        tbad = 1'b0;
        dbad = 1'b0;
        foreach (mv_q[k]) begin
            if (mv_q[k] - t0 != 2 + k * (1 + G)) tbad = 1'b1;
            if (dirs[k] != e_dir) dbad = 1'b1;
        end
        if (e_mv > 0) begin
            chk({nm, " move timing"}, tbad, 0);
            chk({nm, " move dir"}, dbad, 0);
            chk({nm, " setup dir"}, setup_dir, e_dir);
        end
        if (ld && ld_q.size() > 0) chk({nm, " load cycle"}, ld_q[0] - t0, 1);
        chk_mcnt(nm);
        m_cur = e_cur;
    endtask

    typedef struct {
        bit ld;
        int tap;
        int e_cur;
        int e_mv;
        int e_lat;
        bit e_dir;
    } vec_t;

    vec_t vt[6];

    initial begin
        rq.REQ_VALID = 1'b0;
        rq.REQ_LOAD  = 1'b0;
        rq.REQ_TAP   = '0;

        vt[0] = '{ld: 0, tap: 5,   e_cur: 5,   e_mv: 4,   e_lat: 22,   e_dir: 1};
        vt[1] = '{ld: 0, tap: 2,   e_cur: 2,   e_mv: 3,   e_lat: 17,   e_dir: 0};
        vt[2] = '{ld: 0, tap: 2,   e_cur: 2,   e_mv: 0,   e_lat: 1,    e_dir: 0};
        vt[3] = '{ld: 1, tap: 77,  e_cur: 1,   e_mv: 0,   e_lat: 6,    e_dir: 0};
        vt[4] = '{ld: 0, tap: 300, e_cur: 255, e_mv: 254, e_lat: 1272, e_dir: 1};
        vt[5] = '{ld: 0, tap: 250, e_cur: 250, e_mv: 5,   e_lat: 27,   e_dir: 0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("init");
        reset_release("init");

        foreach (vt[i])
            do_req($sformatf("vec%0d", i), vt[i].ld, vt[i].tap, 0,
                   vt[i].e_cur, vt[i].e_mv, vt[i].e_lat, vt[i].e_dir, 1'b0);

        // Out-of-range after the 3rd step of a +6 request from INIT_TAP.
        do_req("oor load", 1'b1, 0, 0, INIT_TAP, 0, 2 + G, 1'b0, 1'b0);
        do_req("oor", 1'b0, INIT_TAP + 6, 3, INIT_TAP + 2, 3, 2 + 3 * (1 + G), 1'b1, 1'b1);
        chk("oor sticky", err_oor, 1);
        tick();
        chk("oor still sticky", err_oor, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("oor cleared", err_oor, 0);

        // Random requests against the tap/latency model.
        for (int i = 0; i < 12; i++) begin
            bit ld;
            int tap, tgt, n, lat;
            ld  = ($urandom_range(0, 5) == 0);
            tap = m_cur + int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 5) == 0) tap = $urandom_range(256, 511);
            if (tap < 0) tap = 0;
            tgt = (tap > MAX_TAP) ? MAX_TAP : tap;
            if (ld)
                do_req($sformatf("rnd%0d", i), 1'b1, tap, 0, INIT_TAP, 0, 2 + G, 1'b0, 1'b0);
            else begin
                n   = (tgt > m_cur) ? tgt - m_cur : m_cur - tgt;
                lat = (n == 0) ? 1 : 2 + n * (1 + G);
                do_req($sformatf("rnd%0d", i), 1'b0, tap, 0, tgt, n, lat, tgt > m_cur, 1'b0);
            end
        end

        // Reset in the middle of a request: dropped with no DONE, fresh LOAD after release.
        begin
            int w, tap;
            bit saw_done;
            tap = (m_cur < 128) ? m_cur + 3 : m_cur - 3;
            w = 0;
            while (rq.REQ_READY !== 1'b1 && w < BOUND) begin tick(); w++; end
            rq.REQ_VALID = 1'b1;
            rq.REQ_LOAD  = 1'b0;
            rq.REQ_TAP   = TAP_W'(tap);
            mv_q.delete();
            tick();
            rq.REQ_VALID = 1'b0;
            w = 0;
            saw_done = 1'b0;
            while (mv_q.size() < 1 && w < BOUND) begin tick(); w++; end
            chk("midrst first move", mv_q.size(), 1);
            tick();
            rst = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (rq.DONE === 1'b1) saw_done = 1'b1;
                tick();
            end
            chk("midrst no done", saw_done, 0);
            chk_reset_outs("midrst");
            reset_release("midrst");
        end

        chk("pulse spacing", proto_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
